// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared parameters and helpers for the pipelined CLA adder
package cla_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_GROUP = 4;

    // Number of CLA slices, which is also the pipeline depth in clocks.
    function automatic int ng(input int width, input int group);
        return width / group;
    endfunction

endpackage

// File: rtl/cla_group.sv
// rtl/cla_group.sv - combinational GROUP-bit carry-lookahead slice
//
// Ports:
//   a, b      slice operands (b already inverted by the caller for subtract)
//   ci        carry into bit 0 of the slice
//   s         slice sum
//   co        carry out of the slice MSB
//   c_msb_in  carry into the slice MSB (used for signed overflow on the top slice)
module cla_group #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             ci,
    output logic [GROUP-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    logic [GROUP-1:0] p;
    logic [GROUP-1:0] g;
    logic [GROUP:0]   c;

    // Each carry is built directly from the generate/propagate terms of all
    // lower bits in the slice, so no carry depends on another carry.
    always_comb begin
        logic pp;
        logic cc;
        pp   = 1'b1;
        cc   = 1'b0;
        p    = a ^ b;
        g    = a & b;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < GROUP; i++) begin
            pp = 1'b1;
            cc = 1'b0;
            for (int j = i; j >= 0; j--) begin
                cc = cc | (g[j] & pp);
                pp = pp & p[j];
            end
            c[i+1] = cc | (pp & ci);
        end
    end

    assign s        = p ^ c[GROUP-1:0];
    assign co       = c[GROUP];
    assign c_msb_in = c[GROUP-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// rtl/cla_pipe_adder.sv - pipelined carry-lookahead adder/subtractor, one slice per stage
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      operand beat handshake (A, B, sub, cin)
//   sub                    1: A-B (cin ignored), 0: A+B+cin
//   out_valid/out_ready    result beat handshake (sum, cout, ovf)
//   sum                    result modulo 2^WIDTH
//   cout                   carry out of MSB (subtract: 1 = no borrow)
//   ovf                    signed overflow
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int GROUP = DEF_GROUP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NG = ng(WIDTH, GROUP);

    if ((GROUP < 1) || (WIDTH % GROUP != 0)) begin : g_param_check
        $fatal(1, "cla_pipe_adder: WIDTH must be a non-zero multiple of GROUP");
    end

    // Per-stage registers. Operands travel whole so each stage can pick its
    // own slice; the sum accumulates one slice per stage.
    logic [WIDTH-1:0] a_q [NG];
    logic [WIDTH-1:0] b_q [NG];
    logic [WIDTH-1:0] s_q [NG];
    logic             v_q [NG];
    logic             c_q [NG];
    logic             o_q [NG];

    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    // The whole pipe, bubbles included, freezes only when a finished result
    // is being refused downstream.
    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;

    assign b_eff = sub ? ~B : B;
    assign c_eff = sub | cin;

    for (genvar k = 0; k < NG; k++) begin : g_stage
        logic [WIDTH-1:0] a_i;
        logic [WIDTH-1:0] b_i;
        logic [WIDTH-1:0] s_i;
        logic [WIDTH-1:0] s_n;
        logic             v_i;
        logic             c_i;
        logic [GROUP-1:0] gs;
        logic             gco;
        logic             gcm;

        if (k == 0) begin : g_first
            assign a_i = A;
            assign b_i = b_eff;
            assign s_i = '0;
            assign v_i = in_valid;
            assign c_i = c_eff;
        end else begin : g_next
            assign a_i = a_q[k-1];
            assign b_i = b_q[k-1];
            assign s_i = s_q[k-1];
            assign v_i = v_q[k-1];
            assign c_i = c_q[k-1];
        end

        cla_group #(
            .GROUP (GROUP)
        ) u_grp (
            .a        (a_i[k*GROUP +: GROUP]),
            .b        (b_i[k*GROUP +: GROUP]),
            .ci       (c_i),
            .s        (gs),
            .co       (gco),
            .c_msb_in (gcm)
        );

        always_comb begin
            s_n                    = s_i;
            s_n[k*GROUP +: GROUP]  = gs;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
                o_q[k] <= 1'b0;
            end else if (en) begin
                v_q[k] <= v_i;
                a_q[k] <= a_i;
                b_q[k] <= b_i;
                s_q[k] <= s_n;
                c_q[k] <= gco;
                // Only meaningful on the top slice, where gcm is the carry
                // into the word MSB.
                o_q[k] <= gcm ^ gco;
            end
        end
    end

    assign out_valid = v_q[NG-1];
    assign sum       = s_q[NG-1];
    assign cout      = c_q[NG-1];
    assign ovf       = o_q[NG-1];

endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb/tb_cla_pipe_adder.sv - self-checking bench for cla_pipe_adder
module tb_cla_pipe_adder;
    import cla_pkg::*;

    localparam int W   = 16;
    localparam int G   = 4;
    localparam int NGL = ng(W, G);

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         sub;
    logic         cin;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    cla_pipe_adder #(
        .WIDTH (W),
        .GROUP (G)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sub       (sub),
        .cin       (cin),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int outs   = 0;
    logic [W+1:0] sb [$];
    logic         hold_p = 1'b0;
    logic [W+1:0] hold_v = '0;
    logic         rnd_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // {cout, ovf, sum}
    function automatic logic [W+1:0] model(input logic s, input logic ci,
                                           input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] bx;
        logic [W:0]   r;
        logic         ce;
        bx = s ? ~b : b;
        ce = s ? 1'b1 : ci;
        r  = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, ce};
        return {r[W], (a[W-1] == bx[W-1]) && (r[W-1] != a[W-1]), r[W-1:0]};
    endfunction

    // Scoreboard: push on accept, pop on drain, both seen at the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            hold_p <= 1'b0;
        end else begin
            chk("in_ready_rule", {31'd0, in_ready}, {31'd0, !(out_valid && !out_ready)});
            if (hold_p)
                chk("hold_stable", {13'd0, out_valid, cout, ovf, sum}, {13'd0, 1'b1, hold_v});
            if (in_valid && in_ready)
                sb.push_back(model(sub, cin, A, B));
            if (out_valid && out_ready) begin
                outs <= outs + 1;
                if (sb.size() == 0)
                    chk("spurious_out", {31'd0, out_valid}, 32'd0);
                else
                    chk("result", {14'd0, cout, ovf, sum}, {14'd0, sb.pop_front()});
            end
            hold_p <= out_valid && !out_ready;
            hold_v <= {cout, ovf, sum};
        end
    end

    task automatic send(input logic s, input logic ci, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        sub      = s;
        cin      = ci;
        A        = a;
        B        = b;
        in_valid = 1'b1;
        n        = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100)
            chk("accept_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic single(input string tag, input logic s, input logic ci,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] e_sum, input logic e_cout, input logic e_ovf);
        int lat;
        send(s, ci, a, b);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, NGL);
        chk({tag, "_sum"}, {16'd0, sum}, {16'd0, e_sum});
        chk({tag, "_cout"}, {31'd0, cout}, {31'd0, e_cout});
        chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, e_ovf});
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200)
            chk("drain_timeout", sb.size(), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int outs0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        sub       = 1'b0;
        cin       = 1'b0;
        A         = '0;
        B         = '0;
        out_ready = 1'b1;
        rnd_done  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum", {16'd0, sum}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        single("add_wrap",  1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
        single("sub_borrow", 1'b1, 1'b0, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0);
        single("sub_ovf",   1'b1, 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1);
        single("add_ovf",   1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
        single("add_xgrp",  1'b0, 1'b0, 16'h0FFF, 16'h0001, 16'h1000, 1'b0, 1'b0);
        single("add_cin",   1'b0, 1'b1, 16'h00FF, 16'h0000, 16'h0100, 1'b0, 1'b0);
        drain();

        // Eight back-to-back beats with a three-cycle downstream stall.
        outs0 = outs;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(i[0], i[1], 16'(i * 16'h2345 + 16'h0FF0), 16'(16'hF00F - i * 16'h1111));
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("burst_count", outs - outs0, 32'd8);

        // Reset with three beats in flight.
        for (int i = 0; i < 3; i++)
            send(1'b0, 1'b0, 16'(16'h1000 + i), 16'h0001);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_flush_valid", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("rst_no_stale", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk);
        #1;

        // Random sweep with independent downstream backpressure.
        outs0 = outs;
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    if ($urandom_range(0, 7) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         16'($urandom), 16'($urandom));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();
        chk("rand_count", outs - outs0, 32'd10000);
        chk("final_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
